// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash device model and its controller:
// opcodes, status/config register bit positions and the device FSM encoding.
package spi_flash_pkg;

  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_WRDI  = 8'h04;
  localparam logic [7:0] CMD_RDSR1 = 8'h05;
  localparam logic [7:0] CMD_RDCR  = 8'h35;
  localparam logic [7:0] CMD_WRR   = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_PP    = 8'h02;
  localparam logic [7:0] CMD_QOR   = 8'h6B;

  localparam int SR1_WIP = 0;
  localparam int SR1_WEL = 1;
  localparam int CR_QUAD = 1;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, TX1, TXQ, RX, IGNORE
  } state_e;

endpackage

// File: rtl/spi_flash_mem_array.sv
// Byte array for the flash model: combinational read port, AND-program write
// port (bits only go 1->0), and a post-reset sweep that restores the erased value.
module spi_flash_mem_array #(
  parameter int         ADDR_BITS = 8,
  parameter logic [7:0] INIT_BYTE = 8'hFF
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  output logic                 init_busy
);

  localparam int                   DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  logic [7:0]           mem_q [DEPTH];
  logic                 sweep_q, sweep_d;
  logic [ADDR_BITS-1:0] sweep_addr_q, sweep_addr_d;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [7:0]           mem_wdata;

  // Sweep pointer advance; the sweep ends after the last address is written.
  always_comb begin
    sweep_d      = sweep_q;
    sweep_addr_d = sweep_addr_q;
    if (sweep_q) begin
      sweep_addr_d = sweep_addr_q + ADDR_BITS'(1);
      if (sweep_addr_q == LAST_ADDR) sweep_d = 1'b0;
    end
  end

  // Sweep state register; reset arms a fresh sweep starting at address 0.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      sweep_q      <= 1'b1;
      sweep_addr_q <= '0;
    end else begin
      sweep_q      <= sweep_d;
      sweep_addr_q <= sweep_addr_d;
    end
  end

  // Write-port mux: the sweep owns the port until it finishes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = mem_q[wr_addr] & wr_data;
    if (!reset) begin
      if (sweep_q) begin
        mem_we    = 1'b1;
        mem_waddr = sweep_addr_q;
        mem_wdata = INIT_BYTE;
      end else if (wr_en) begin
        mem_we = 1'b1;
      end
    end
  end

  // Array storage.
  // NOTE: the array has no reset branch so it maps onto RAM; the sweep above restores it instead.
  always_ff @(posedge clk_50MHz) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_data   = mem_q[rd_addr];
  assign init_busy = sweep_q & ~reset;

endmodule

// File: rtl/spi_flash_responder.sv
// Device-side SPI flash model: one SPI bit per clk_50MHz cycle while cs_n is low.
// Decodes commands, keeps SR1/CR, programs/reads the byte array on one or four lanes.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int         ADDR_BITS    = 8,
  parameter int         BUSY_CYCLES  = 64,
  parameter int         DUMMY_CYCLES = 8,
  parameter logic [7:0] INIT_BYTE    = 8'hFF
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       si,
  output logic [3:0] dq_out,
  output logic [3:0] dq_oe,
  output logic [7:0] sr1,
  output logic [7:0] cr,
  output logic       busy
);

  localparam int                   BC_W       = $clog2(BUSY_CYCLES + 1);
  localparam logic [BC_W-1:0]      BUSY_LOAD  = BC_W'(BUSY_CYCLES);
  localparam logic [4:0]           DUMMY_LAST = 5'(DUMMY_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] PAGE_MASK  = ADDR_BITS'(255);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE   = ADDR_BITS'(1);

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [6:0]           shift_q, shift_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           tx_q, tx_d;
  logic [1:0]           rx_idx_q, rx_idx_d;
  logic                 pend_wren_q, pend_wren_d, pend_wrdi_q, pend_wrdi_d;
  logic                 prog_done_q, prog_done_d;
  logic                 wel_q, wel_d, wip_q, wip_d;
  logic [BC_W-1:0]      busy_cnt_q, busy_cnt_d;
  logic [5:0]           sr1_hi_q, sr1_hi_d;
  logic [7:0]           cr_q, cr_d;
  logic [3:0]           dq_out_q, dq_out_d, dq_oe_q, dq_oe_d;

  logic [7:0]           cmd_byte, src_cmd, tx1_src, sr1_w, rd_data;
  logic [ADDR_BITS-1:0] addr_shift, rd_addr, mem_wr_addr;
  logic                 mem_wr_en, init_busy, device_busy, load_tx1, load_txq;

  spi_flash_mem_array #(.ADDR_BITS(ADDR_BITS), .INIT_BYTE(INIT_BYTE)) u_mem (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (mem_wr_en),
    .wr_addr   (mem_wr_addr),
    .wr_data   (cmd_byte),
    .init_busy (init_busy)
  );

  // Live SR1 view; the init sweep reports as work-in-progress.
  always_comb begin
    sr1_w          = {sr1_hi_q, 2'b00};
    sr1_w[SR1_WEL] = wel_q;
    sr1_w[SR1_WIP] = wip_q | init_busy;
  end

  assign device_busy = sr1_w[SR1_WIP];
  assign cmd_byte    = {shift_q, si};
  assign addr_shift  = {addr_q[ADDR_BITS-2:0], si};
  assign rd_addr     = (state_q == ADDR) ? addr_shift : addr_q;
  assign src_cmd     = (state_q == CMD) ? cmd_byte : cmd_q;
  assign tx1_src     = (src_cmd == CMD_RDSR1) ? sr1_w :
                       (src_cmd == CMD_RDCR)  ? cr_q  : rd_data;

  // Next-state, register updates and output data for every SPI cycle.
  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  shift_d = shift_q;  addr_d = addr_q;
    cmd_d = cmd_q;  tx_d = tx_q;  rx_idx_d = rx_idx_q;
    pend_wren_d = pend_wren_q;  pend_wrdi_d = pend_wrdi_q;  prog_done_d = prog_done_q;
    wel_d = wel_q;  wip_d = wip_q;  busy_cnt_d = busy_cnt_q;
    sr1_hi_d = sr1_hi_q;  cr_d = cr_q;  dq_out_d = dq_out_q;  dq_oe_d = dq_oe_q;
    mem_wr_en = 1'b0;  mem_wr_addr = addr_q;  load_tx1 = 1'b0;  load_txq = 1'b0;

    if (wip_q) begin
      if (busy_cnt_q <= BC_W'(1)) begin
        wip_d      = 1'b0;
        busy_cnt_d = '0;
      end else begin
        busy_cnt_d = busy_cnt_q - BC_W'(1);
      end
    end

    if (cs_n) begin
      state_d  = IDLE;
      dq_oe_d  = 4'h0;
      dq_out_d = 4'h0;
      if (pend_wren_q) wel_d = 1'b1;
      if (pend_wrdi_q) wel_d = 1'b0;
      if (prog_done_q) begin
        wel_d      = 1'b0;
        wip_d      = 1'b1;
        busy_cnt_d = BUSY_LOAD;
      end
      pend_wren_d = 1'b0;
      pend_wrdi_d = 1'b0;
      prog_done_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          shift_d = {6'b0, si};
          cnt_d   = 5'd1;
          state_d = CMD;
        end
        CMD: begin
          shift_d = cmd_byte[6:0];
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d    = '0;
            cmd_d    = cmd_byte;
            rx_idx_d = '0;
            state_d  = IGNORE;
            if (!device_busy || cmd_byte == CMD_RDSR1 || cmd_byte == CMD_RDCR) begin
              case (cmd_byte)
                CMD_WREN:             pend_wren_d = 1'b1;
                CMD_WRDI:             pend_wrdi_d = 1'b1;
                CMD_RDSR1, CMD_RDCR:  load_tx1 = 1'b1;
                CMD_WRR:              if (wel_q) state_d = RX;
                CMD_READ:             state_d = ADDR;
                CMD_PP:               if (wel_q) state_d = ADDR;
                CMD_QOR:              if (cr_q[CR_QUAD]) state_d = ADDR;
                default:              ;
              endcase
            end
          end
        end
        ADDR: begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d = '0;
            if (cmd_q == CMD_READ) begin
              load_tx1 = 1'b1;
              addr_d   = addr_shift + ADDR_ONE;
            end else if (cmd_q == CMD_PP) begin
              state_d = RX;
            end else begin
              state_d = DUMMY;
            end
          end
        end
        DUMMY: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == DUMMY_LAST) begin
            load_txq = 1'b1;
            addr_d   = addr_q + ADDR_ONE;
          end
        end
        TX1: begin
          if (cnt_q == 5'd0) begin
            load_tx1 = 1'b1;
            addr_d   = addr_q + ADDR_ONE;
          end else begin
            dq_out_d = {2'b00, tx_q[7], 1'b0};
            tx_d     = {tx_q[6:0], 1'b0};
            cnt_d    = cnt_q - 5'd1;
          end
        end
        TXQ: begin
          if (cnt_q == 5'd0) begin
            load_txq = 1'b1;
            addr_d   = addr_q + ADDR_ONE;
          end else begin
            dq_out_d = tx_q[3:0];
            cnt_d    = '0;
          end
        end
        RX: begin
          shift_d = cmd_byte[6:0];
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d       = '0;
            prog_done_d = 1'b1;
            if (cmd_q == CMD_PP) begin
              mem_wr_en = 1'b1;
              addr_d    = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_ONE) & PAGE_MASK);
            end else begin
              if (rx_idx_q == 2'd0) sr1_hi_d = cmd_byte[7:2];
              if (rx_idx_q == 2'd1) cr_d = cmd_byte;
              if (rx_idx_q != 2'd2) rx_idx_d = rx_idx_q + 2'd1;
            end
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase

      if (load_tx1) begin
        state_d  = TX1;
        dq_oe_d  = 4'b0010;
        dq_out_d = {2'b00, tx1_src[7], 1'b0};
        tx_d     = {tx1_src[6:0], 1'b0};
        cnt_d    = 5'd7;
      end
      if (load_txq) begin
        state_d  = TXQ;
        dq_oe_d  = 4'hF;
        dq_out_d = rd_data[7:4];
        tx_d     = rd_data;
        cnt_d    = 5'd1;
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= IDLE;  cnt_q <= '0;  shift_q <= '0;  addr_q <= '0;
      cmd_q <= '0;  tx_q <= '0;  rx_idx_q <= '0;
      pend_wren_q <= 1'b0;  pend_wrdi_q <= 1'b0;  prog_done_q <= 1'b0;
      wel_q <= 1'b0;  wip_q <= 1'b0;  busy_cnt_q <= '0;
      sr1_hi_q <= '0;  cr_q <= '0;  dq_out_q <= '0;  dq_oe_q <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  shift_q <= shift_d;  addr_q <= addr_d;
      cmd_q <= cmd_d;  tx_q <= tx_d;  rx_idx_q <= rx_idx_d;
      pend_wren_q <= pend_wren_d;  pend_wrdi_q <= pend_wrdi_d;  prog_done_q <= prog_done_d;
      wel_q <= wel_d;  wip_q <= wip_d;  busy_cnt_q <= busy_cnt_d;
      sr1_hi_q <= sr1_hi_d;  cr_q <= cr_d;  dq_out_q <= dq_out_d;  dq_oe_q <= dq_oe_d;
    end
  end

  assign dq_out = dq_out_q;
  assign dq_oe  = dq_oe_q;
  assign sr1    = sr1_w;
  assign cr     = cr_q;
  assign busy   = sr1_w[SR1_WIP];

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: inputs driven on the falling edge,
// outputs observed 1 ns after the rising edge.
module tb_spi_flash_responder;

  logic       clk_50MHz = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       si;
  logic [3:0] dq_out;
  logic [3:0] dq_oe;
  logic [7:0] sr1;
  logic [7:0] cr;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  spi_flash_responder dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .cs_n      (cs_n),
    .si        (si),
    .dq_out    (dq_out),
    .dq_oe     (dq_oe),
    .sr1       (sr1),
    .cr        (cr),
    .busy      (busy)
  );

  always #10 clk_50MHz = ~clk_50MHz;
  always @(posedge clk_50MHz) edge_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 1ms", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic b);
    @(negedge clk_50MHz);
    cs_n = 1'b0;
    si   = b;
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_50MHz);
      cs_n = 1'b1;
      si   = 1'b0;
      @(posedge clk_50MHz);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick(b[i]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) tick(a[i]);
  endtask

  // Capture n bits from dq_out[1]; oe_ok stays 1 only if dq_oe was 4'b0010 throughout.
  task automatic recv_single(input int n, output logic [15:0] val, output logic oe_ok);
    val   = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      val = {val[14:0], dq_out[1]};
      if (dq_oe !== 4'b0010) oe_ok = 1'b0;
      tick(1'b0);
    end
  endtask

  // n ticks with si=0; oe_quiet stays 1 only if dq_oe stayed 0.
  task automatic quiet_ticks(input int n, output logic oe_quiet);
    oe_quiet = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick(1'b0);
      if (dq_oe !== 4'h0) oe_quiet = 1'b0;
    end
  endtask

  task automatic wait_not_busy(input int limit, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < limit) begin
      @(posedge clk_50MHz);
      #1;
      cycles++;
    end
  endtask

  task automatic do_read(input logic [23:0] a, input int n, output logic [15:0] val,
                         output logic oe_ok);
    send_byte(8'h03);
    send_addr(a);
    recv_single(n, val, oe_ok);
    idle(1);
  endtask

  initial begin
    logic [15:0] val;
    logic        ok;
    logic [3:0]  nib [4];
    int          cycles, t0;

    reset = 1'b1;
    cs_n  = 1'b1;
    si    = 1'b0;
    repeat (3) @(posedge clk_50MHz);
    #1;
    check("reset_dq_out", 32'(dq_out), 32'h0);
    check("reset_dq_oe",  32'(dq_oe),  32'h0);
    check("reset_sr1",    32'(sr1),    32'h0);
    check("reset_cr",     32'(cr),     32'h0);
    check("reset_busy",   32'(busy),   32'h0);

    // Init sweep keeps busy high for 256 cycles.
    @(negedge clk_50MHz);
    reset = 1'b0;
    #1;
    check("sweep_busy_start", 32'(busy), 32'h1);
    wait_not_busy(1000, cycles);
    check("sweep_cycles", 32'(cycles), 32'd256);

    // RDSR1: two bytes of 0x00, oe only in data phase.
    for (int i = 7; i >= 1; i--) tick(CMD_RDSR1_BIT(i));
    check("rdsr1_oe_cmd_phase", 32'(dq_oe), 32'h0);
    tick(1'b1);
    recv_single(16, val, ok);
    check("rdsr1_data", 32'(val), 32'h0000);
    check("rdsr1_oe_data", 32'(ok), 32'h1);
    idle(1);
    check("rdsr1_oe_after_cs", 32'(dq_oe), 32'h0);

    // READ of erased array.
    do_read(24'h000010, 16, val, ok);
    check("read_erased", 32'(val), 32'hFFFF);
    check("read_erased_oe", 32'(ok), 32'h1);

    // WREN then PP at 0xFF with page wrap.
    send_byte(8'h06);
    idle(1);
    check("wren_sr1", 32'(sr1), 32'h02);
    send_byte(8'h02);
    send_addr(24'h0000FF);
    send_byte(8'hA5);
    send_byte(8'h3C);
    idle(1);
    t0 = edge_cnt;
    check("pp_sr1_wip", 32'(sr1), 32'h01);
    check("pp_busy", 32'(busy), 32'h1);

    // READ while WIP is ignored.
    send_byte(8'h03);
    send_addr(24'h0000FF);
    quiet_ticks(2, ok);
    check("read_during_wip_oe", 32'(ok & (dq_oe === 4'h0)), 32'h1);
    idle(1);
    // RDSR1 is still honoured and shows WIP.
    send_byte(8'h05);
    recv_single(8, val, ok);
    check("rdsr1_during_wip", 32'(val), 32'h0001);
    idle(1);
    wait_not_busy(200, cycles);
    check("wip_duration", 32'(edge_cnt - t0), 32'd64);
    check("sr1_after_wip", 32'(sr1), 32'h00);

    do_read(24'h0000FF, 16, val, ok);
    check("read_ff_wrap", 32'(val), 32'hA53C);
    do_read(24'h000000, 8, val, ok);
    check("read_00", 32'(val), 32'h003C);

    // PP without WREN has no effect.
    send_byte(8'h02);
    send_addr(24'h000020);
    send_byte(8'h00);
    idle(1);
    check("pp_nowel_sr1", 32'(sr1), 32'h00);
    do_read(24'h000020, 8, val, ok);
    check("pp_nowel_read", 32'(val), 32'h00FF);

    // QOR with QUAD clear stays silent.
    send_byte(8'h6B);
    send_addr(24'h0000FF);
    quiet_ticks(12, ok);
    check("qor_noquad_oe", 32'(ok), 32'h1);
    idle(1);

    // WREN, WRR 0x00/0x02.
    send_byte(8'h06);
    idle(1);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h02);
    idle(1);
    check("wrr_cr", 32'(cr), 32'h02);
    check("wrr_sr1", 32'(sr1), 32'h01);
    wait_not_busy(200, cycles);
    check("wrr_busy_clear", 32'(busy), 32'h0);
    send_byte(8'h35);
    recv_single(8, val, ok);
    check("rdcr", 32'(val), 32'h0002);
    idle(1);

    // QOR at 0xFF: 8 dummy cycles, then nibbles A,5,3,C.
    send_byte(8'h6B);
    send_addr(24'h0000FF);
    quiet_ticks(7, ok);
    check("qor_dummy_oe", 32'(ok), 32'h1);
    tick(1'b0);
    check("qor_oe", 32'(dq_oe), 32'hF);
    for (int i = 0; i < 4; i++) begin
      nib[i] = dq_out;
      if (i < 3) tick(1'b0);
    end
    check("qor_nibbles", 32'({nib[0], nib[1], nib[2], nib[3]}), 32'hA53C);
    check("qor_oe_end", 32'(dq_oe), 32'hF);
    idle(1);
    check("qor_oe_after_cs", 32'(dq_oe), 32'h0);

    // Programming ANDs into existing data.
    send_byte(8'h06);
    idle(1);
    send_byte(8'h02);
    send_addr(24'h0000FF);
    send_byte(8'hF0);
    idle(1);
    wait_not_busy(200, cycles);
    do_read(24'h0000FF, 8, val, ok);
    check("pp_and", 32'(val), 32'h00A0);

    // cs_n abort mid-address, then RDSR1 works.
    send_byte(8'h03);
    for (int i = 0; i < 10; i++) tick(1'b1);
    idle(1);
    check("abort_oe", 32'(dq_oe), 32'h0);
    send_byte(8'h05);
    check("abort_rdsr1_oe", 32'(dq_oe), 32'h2);
    recv_single(8, val, ok);
    check("abort_rdsr1", 32'(val), 32'h0000);
    idle(1);

    // Reset mid-transaction restores everything including memory.
    send_byte(8'h03);
    for (int i = 0; i < 4; i++) tick(1'b0);
    @(negedge clk_50MHz);
    reset = 1'b1;
    cs_n  = 1'b1;
    @(posedge clk_50MHz);
    #1;
    check("midreset_cr", 32'(cr), 32'h0);
    check("midreset_sr1", 32'(sr1), 32'h0);
    @(negedge clk_50MHz);
    reset = 1'b0;
    #1;
    wait_not_busy(1000, cycles);
    check("midreset_sweep", 32'(cycles), 32'd256);
    do_read(24'h0000FF, 8, val, ok);
    check("midreset_mem", 32'(val), 32'h00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bits of the RDSR1 opcode 0x05, MSB first.
  function automatic logic CMD_RDSR1_BIT(input int i);
    logic [7:0] op;
    op = 8'h05;
    return op[i];
  endfunction

endmodule
